mem_bank_pwr_seq: RTL

Power-gate sequencer for the on-chip memory banks of the MCU's memory subsystem. It accepts one bank power-on/off request at a time from the power manager and drives the bank's clock gate, isolation and active-low power-switch control in a fixed order. It then waits for the switch cells' active-low acknowledge and reports completion or timeout. It is the initiator side of the bank `switch_n`/`switch_ack_n` handshake.

---
 rtl/mem_bank_pwr_seq.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_bank_pwr_seq.sv
// Power-gate sequencer: walks one memory bank at a time through clock gate, isolation and power switch.
// Define MEM_BANK_PWR_SEQ_ACK_SYNC_EN to put a two-flop synchronizer on switch_ack_n_i.
module mem_bank_pwr_seq #(
  parameter int NumBanks   = 16,
  parameter int AckTimeout = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [$clog2(NumBanks)-1:0] req_bank_i,
  input  logic                        req_on_i,
  output logic                        done_o,
  output logic                        err_o,
  output logic [NumBanks-1:0]         bank_on_o,
  output logic [NumBanks-1:0]         clk_gate_o,
  output logic [NumBanks-1:0]         iso_o,
  output logic [NumBanks-1:0]         switch_n_o,
  input  logic [NumBanks-1:0]         switch_ack_n_i
);

  localparam int             BankW      = $clog2(NumBanks);
  localparam logic [BankW:0] BankLimit  = NumBanks[BankW:0];
  localparam logic [7:0]     TimeoutCnt = AckTimeout[7:0];

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GATE,
    ST_ISO,
    ST_SW_OFF,
    ST_WAIT,
    ST_SW_ON,
    ST_UNISO,
    ST_UNGATE,
    ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BankW-1:0]    r_bank;
  logic [BankW-1:0]    w_bank_nxt;
  logic                r_on;
  logic                w_on_nxt;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic [7:0]          w_cnt_inc;
  logic                r_ready;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic [NumBanks-1:0] r_bank_on;
  logic [NumBanks-1:0] w_bank_on_nxt;
  logic [NumBanks-1:0] r_clk_gate;
  logic [NumBanks-1:0] w_clk_gate_nxt;
  logic [NumBanks-1:0] r_iso;
  logic [NumBanks-1:0] w_iso_nxt;
  logic [NumBanks-1:0] r_switch_n;
  logic [NumBanks-1:0] w_switch_n_nxt;
  logic [NumBanks-1:0] w_ack_n;
  logic                w_ack_match;
  logic                w_bank_bad;

`ifdef MEM_BANK_PWR_SEQ_ACK_SYNC_EN
  logic [NumBanks-1:0] r_ack_meta;
  logic [NumBanks-1:0] r_ack_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack_meta <= '0;
      r_ack_sync <= '0;
    end else begin
      r_ack_meta <= switch_ack_n_i;
      r_ack_sync <= r_ack_meta;
    end
  end

  assign w_ack_n = r_ack_sync;
`else
  assign w_ack_n = switch_ack_n_i;
`endif

  // Only the latched bank's acknowledge is looked at; other banks' acks are don't-care.
  assign w_ack_match = (w_ack_n[r_bank] == r_switch_n[r_bank]);
  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_bank_bad  = ({1'b0, req_bank_i} >= BankLimit);

  always_comb begin
    w_state_nxt    = r_state;
    w_bank_nxt     = r_bank;
    w_on_nxt       = r_on;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_bank_on_nxt  = r_bank_on;
    w_clk_gate_nxt = r_clk_gate;
    w_iso_nxt      = r_iso;
    w_switch_n_nxt = r_switch_n;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_bank_nxt = req_bank_i;
          w_on_nxt   = req_on_i;
          if (w_bank_bad) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else if (r_bank_on[req_bank_i] == req_on_i) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else if (req_on_i) begin
            w_state_nxt                = ST_SW_ON;
            w_switch_n_nxt[req_bank_i] = 1'b0;
          end else begin
            w_state_nxt                = ST_GATE;
            w_clk_gate_nxt[req_bank_i] = 1'b1;
          end
        end
      end

      ST_GATE: begin
        w_state_nxt       = ST_ISO;
        w_iso_nxt[r_bank] = 1'b1;
      end

      ST_ISO: begin
        w_state_nxt            = ST_SW_OFF;
        w_switch_n_nxt[r_bank] = 1'b1;
      end

      ST_SW_OFF: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end

      ST_SW_ON: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end

      // A match wins over a timeout landing in the same cycle; on timeout every control bit is left as is.
      ST_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_ack_match) begin
          if (r_on) begin
            w_state_nxt       = ST_UNISO;
            w_iso_nxt[r_bank] = 1'b0;
          end else begin
            w_state_nxt           = ST_DONE;
            w_done_nxt            = 1'b1;
            w_bank_on_nxt[r_bank] = 1'b0;
          end
        end else if (w_cnt_inc == TimeoutCnt) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end
      end

      ST_UNISO: begin
        w_state_nxt            = ST_UNGATE;
        w_clk_gate_nxt[r_bank] = 1'b0;
      end

      ST_UNGATE: begin
        w_state_nxt           = ST_DONE;
        w_done_nxt            = 1'b1;
        w_bank_on_nxt[r_bank] = 1'b1;
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_bank     <= '0;
      r_on       <= 1'b0;
      r_cnt      <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_bank_on  <= '1;
      r_clk_gate <= '0;
      r_iso      <= '0;
      r_switch_n <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bank     <= w_bank_nxt;
      r_on       <= w_on_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ready    <= (w_state_nxt == ST_IDLE);
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_bank_on  <= w_bank_on_nxt;
      r_clk_gate <= w_clk_gate_nxt;
      r_iso      <= w_iso_nxt;
      r_switch_n <= w_switch_n_nxt;
    end
  end

  assign req_ready_o = r_ready;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign bank_on_o   = r_bank_on;
  assign clk_gate_o  = r_clk_gate;
  assign iso_o       = r_iso;
  assign switch_n_o  = r_switch_n;

endmodule
